// File: rtl/jtdd_rom_arb.sv
// Three-requester SDRAM ROM arbiter with one cached word per requester (obj, scr, chr).
// Define JTDD_ARB_RR_EN for round-robin arbitration; fixed priority obj > scr > chr otherwise.
module jtdd_rom_arb #(
    parameter int          OBJ_AW     = 18,
    parameter int          SCR_AW     = 17,
    parameter int          CHR_AW     = 15,
    parameter logic [21:0] OBJ_OFFSET = 22'h00000,
    parameter logic [21:0] SCR_OFFSET = 22'h10000,
    parameter logic [21:0] CHR_OFFSET = 22'h30000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              obj_cs,
    input  logic              scr_cs,
    input  logic              chr_cs,
    input  logic [OBJ_AW-1:0] obj_addr,
    input  logic [SCR_AW-1:0] scr_addr,
    input  logic [CHR_AW-1:0] chr_addr,
    output logic [15:0]       obj_data,
    output logic [15:0]       scr_data,
    output logic [15:0]       chr_data,
    output logic              obj_ok,
    output logic              scr_ok,
    output logic              chr_ok,
    output logic              sdram_req,
    output logic [21:0]       sdram_addr,
    input  logic              sdram_ack,
    input  logic              data_rdy,
    input  logic [15:0]       data_read,
    output logic [1:0]        fsm_state
);

    localparam int AW_A   = (OBJ_AW > SCR_AW) ? OBJ_AW : SCR_AW;
    localparam int AW_MAX = (AW_A > CHR_AW) ? AW_A : CHR_AW;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ACK  = 2'd1,
        WAIT_DATA = 2'd2
    } state_t;

    state_t state, state_next;

    logic              obj_valid, scr_valid, chr_valid;
    logic [OBJ_AW-1:0] obj_saddr;
    logic [SCR_AW-1:0] scr_saddr;
    logic [CHR_AW-1:0] chr_saddr;

    logic [2:0]        pend;
    logic              any_pend;
    logic [1:0]        win, win_q;
    logic [AW_MAX-1:0] sel_addr, lat_addr;
    logic [21:0]       sel_sdram;

    assign obj_ok = obj_cs && obj_valid && (obj_saddr == obj_addr);
    assign scr_ok = scr_cs && scr_valid && (scr_saddr == scr_addr);
    assign chr_ok = chr_cs && chr_valid && (chr_saddr == chr_addr);

    // Index 0 = obj, 1 = scr, 2 = chr throughout.
    always_comb begin
        pend[0]  = obj_cs && (!obj_valid || obj_saddr != obj_addr);
        pend[1]  = scr_cs && (!scr_valid || scr_saddr != scr_addr);
        pend[2]  = chr_cs && (!chr_valid || chr_saddr != chr_addr);
        any_pend = |pend;
    end

`ifdef JTDD_ARB_RR_EN
    logic [1:0] ptr;

    // Search begins at ptr and wraps obj -> scr -> chr -> obj.
    always_comb begin
        win = 2'd0;
        case (ptr)
            2'd1:    win = pend[1] ? 2'd1 : (pend[2] ? 2'd2 : 2'd0);
            2'd2:    win = pend[2] ? 2'd2 : (pend[0] ? 2'd0 : 2'd1);
            default: win = pend[0] ? 2'd0 : (pend[1] ? 2'd1 : 2'd2);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 2'd0;
        end else if (state == IDLE && any_pend) begin
            ptr <= (win == 2'd2) ? 2'd0 : win + 2'd1;
        end
    end
`else
    always_comb begin
        win = 2'd0;
        if (pend[0])      win = 2'd0;
        else if (pend[1]) win = 2'd1;
        else if (pend[2]) win = 2'd2;
    end
`endif

    always_comb begin
        sel_addr  = '0;
        sel_sdram = '0;
        case (win)
            2'd1: begin
                sel_addr  = AW_MAX'(scr_addr);
                sel_sdram = SCR_OFFSET + 22'(scr_addr);
            end
            2'd2: begin
                sel_addr  = AW_MAX'(chr_addr);
                sel_sdram = CHR_OFFSET + 22'(chr_addr);
            end
            default: begin
                sel_addr  = AW_MAX'(obj_addr);
                sel_sdram = OBJ_OFFSET + 22'(obj_addr);
            end
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (any_pend)  state_next = WAIT_ACK;
            WAIT_ACK:  if (sdram_ack) state_next = WAIT_DATA;
            WAIT_DATA: if (data_rdy)  state_next = IDLE;
            default:                  state_next = IDLE;
        endcase
    end

    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request side: the winner is latched at grant time, so requester changes mid-fetch
    // cannot redirect where the returned word is stored.
    always_ff @(posedge clk) begin
        if (rst) begin
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
            win_q      <= 2'd0;
            lat_addr   <= '0;
        end else begin
            case (state)
                IDLE: if (any_pend) begin
                    win_q      <= win;
                    lat_addr   <= sel_addr;
                    sdram_addr <= sel_sdram;
                    sdram_req  <= 1'b1;
                end
                WAIT_ACK: if (sdram_ack) sdram_req <= 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            obj_valid <= 1'b0;
            scr_valid <= 1'b0;
            chr_valid <= 1'b0;
            obj_saddr <= '0;
            scr_saddr <= '0;
            chr_saddr <= '0;
            obj_data  <= '0;
            scr_data  <= '0;
            chr_data  <= '0;
        end else if (state == WAIT_DATA && data_rdy) begin
            case (win_q)
                2'd1: begin
                    scr_valid <= 1'b1;
                    scr_saddr <= lat_addr[SCR_AW-1:0];
                    scr_data  <= data_read;
                end
                2'd2: begin
                    chr_valid <= 1'b1;
                    chr_saddr <= lat_addr[CHR_AW-1:0];
                    chr_data  <= data_read;
                end
                default: begin
                    obj_valid <= 1'b1;
                    obj_saddr <= lat_addr[OBJ_AW-1:0];
                    obj_data  <= data_read;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtdd_rom_arb.sv
// Directed bench for jtdd_rom_arb: expected SDRAM addresses queued on stimulus, popped per request.
module tb_jtdd_rom_arb;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        obj_cs = 1'b0, scr_cs = 1'b0, chr_cs = 1'b0;
    logic [17:0] obj_addr = '0;
    logic [16:0] scr_addr = '0;
    logic [14:0] chr_addr = '0;
    logic [15:0] obj_data, scr_data, chr_data;
    logic        obj_ok, scr_ok, chr_ok;
    logic        sdram_req;
    logic [21:0] sdram_addr;
    logic        sdram_ack = 1'b0;
    logic        data_rdy = 1'b0;
    logic [15:0] data_read = '0;
    logic [1:0]  fsm_state;

    int checks = 0;
    int errors = 0;
    logic [21:0] exp_q[$];
    logic [21:0] cur_addr;
    logic [15:0] d, d2;
    int          n_serve;

    jtdd_rom_arb dut (
        .clk(clk), .rst(rst),
        .obj_cs(obj_cs), .scr_cs(scr_cs), .chr_cs(chr_cs),
        .obj_addr(obj_addr), .scr_addr(scr_addr), .chr_addr(chr_addr),
        .obj_data(obj_data), .scr_data(scr_data), .chr_data(chr_data),
        .obj_ok(obj_ok), .scr_ok(scr_ok), .chr_ok(chr_ok),
        .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
        .data_rdy(data_rdy), .data_read(data_read), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for a request and compares its address with the scoreboard head.
    task automatic wait_req();
        int n = 0;
        while (!sdram_req && n < 20) begin
            tick();
            n++;
        end
        check("req_seen", 32'(sdram_req), 32'd1);
        check("queue_nonempty", 32'(exp_q.size() > 0), 32'd1);
        cur_addr = (exp_q.size() > 0) ? exp_q.pop_front() : 22'h3fffff;
        check("sdram_addr", 32'(sdram_addr), 32'(cur_addr));
    endtask

    task automatic do_ack(input int delay);
        repeat (delay) begin
            tick();
            check("req_held", 32'(sdram_req), 32'd1);
            check("addr_held", 32'(sdram_addr), 32'(cur_addr));
        end
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        check("req_drop", 32'(sdram_req), 32'd0);
        check("state_wait_data", 32'(fsm_state), 32'd2);
    endtask

    task automatic do_data(input logic [15:0] val);
        data_rdy  = 1'b1;
        data_read = val;
        tick();
        data_rdy  = 1'b0;
        data_read = 16'($urandom);
        check("state_idle", 32'(fsm_state), 32'd0);
    endtask

    task automatic check_slot(input logic [21:0] a, input logic [15:0] val);
        if (a >= 22'h30000) begin
            check("chr_ok", 32'(chr_ok), 32'd1);
            check("chr_data", 32'(chr_data), 32'(val));
        end else if (a >= 22'h10000) begin
            check("scr_ok", 32'(scr_ok), 32'd1);
            check("scr_data", 32'(scr_data), 32'(val));
        end else begin
            check("obj_ok", 32'(obj_ok), 32'd1);
            check("obj_data", 32'(obj_data), 32'(val));
        end
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst_req", 32'(sdram_req), 32'd0);
        check("rst_addr", 32'(sdram_addr), 32'd0);
        check("rst_state", 32'(fsm_state), 32'd0);
        check("rst_oks", 32'({obj_ok, scr_ok, chr_ok}), 32'd0);
        check("rst_data", 32'({obj_data | scr_data | chr_data}), 32'd0);
        rst = 1'b0;
        tick();

        // Stray data_rdy / ack while idle with nothing pending
        data_rdy = 1'b1; data_read = 16'h5a5a; sdram_ack = 1'b1;
        tick();
        data_rdy = 1'b0; sdram_ack = 1'b0;
        tick();
        check("stray_state", 32'(fsm_state), 32'd0);
        check("stray_req", 32'(sdram_req), 32'd0);
        check("stray_data", 32'({obj_data | scr_data | chr_data}), 32'd0);
        obj_cs = 1'b1; scr_cs = 1'b1; chr_cs = 1'b1;
        #1;
        check("stray_oks", 32'({obj_ok, scr_ok, chr_ok}), 32'd0);
        obj_cs = 1'b0; scr_cs = 1'b0; chr_cs = 1'b0;
        tick();

        // Single obj fetch: request one cycle after pending, ok one cycle after data_rdy
        obj_cs = 1'b1; obj_addr = 18'h00123;
        exp_q.push_back(22'h00123);
        tick();
        check("req_latency", 32'(sdram_req), 32'd1);
        wait_req();
        do_ack(2);
        check("obj_ok_during_fetch", 32'(obj_ok), 32'd0);
        do_data(16'hbeef);
        check_slot(22'h00123, 16'hbeef);
        tick();
        check("no_refetch", 32'(sdram_req), 32'd0);
        obj_cs = 1'b0;

        // chr fetch, then an address change drops ok combinationally and refetches
        chr_cs = 1'b1; chr_addr = 15'h0010;
        exp_q.push_back(22'h30010);
        tick();
        wait_req();
        do_ack($urandom_range(0, 3));
        d = 16'($urandom);
        do_data(d);
        check_slot(22'h30010, d);
        chr_addr = 15'h0011;
        exp_q.push_back(22'h30011);
        #1;
        check("chr_ok_fall", 32'(chr_ok), 32'd0);
        tick();
        check("chr_req_latency", 32'(sdram_req), 32'd1);
        wait_req();
        do_ack($urandom_range(0, 3));
        d = 16'($urandom);
        do_data(d);
        check_slot(22'h30011, d);
        chr_cs = 1'b0;
        tick();

        // Simultaneous requests: grant order
        obj_addr = 18'h00200; scr_addr = 17'h00300; chr_addr = 15'h0400;
        obj_cs = 1'b1; scr_cs = 1'b1; chr_cs = 1'b1;
        exp_q.push_back(22'h00200);
        exp_q.push_back(22'h10300);
        exp_q.push_back(22'h30400);
`ifdef JTDD_ARB_RR_EN
        exp_q.push_back(22'h00201);
        n_serve = 4;
`else
        n_serve = 3;
`endif
        tick();
        for (int i = 0; i < n_serve; i++) begin
            wait_req();
            do_ack($urandom_range(0, 3));
            d = 16'($urandom);
            do_data(d);
            check_slot(cur_addr, d);
`ifdef JTDD_ARB_RR_EN
            if (i == 0) obj_addr = 18'h00201;
`endif
            if (i < n_serve - 1) begin
                check("b2b_idle_cycle", 32'(sdram_req), 32'd0);
                tick();
                check("b2b_req", 32'(sdram_req), 32'd1);
            end
        end
        obj_cs = 1'b0; scr_cs = 1'b0; chr_cs = 1'b0;
        tick();

        // scr address changes during WAIT_DATA: the latched address is what gets stored
        scr_cs = 1'b1; scr_addr = 17'h00040;
        exp_q.push_back(22'h10040);
        tick();
        wait_req();
        do_ack(1);
        scr_addr = 17'h00041;
        d = 16'h1234;
        do_data(d);
        check("scr_ok_mismatch", 32'(scr_ok), 32'd0);
        scr_addr = 17'h00040;
        #1;
        check_slot(22'h10040, d);
        tick();
        check("scr_no_req", 32'(sdram_req), 32'd0);
        scr_addr = 17'h00041;
        exp_q.push_back(22'h10041);
        tick();
        check("scr_refetch_req", 32'(sdram_req), 32'd1);
        wait_req();
        do_ack(0);
        d2 = 16'h5678;
        do_data(d2);
        check_slot(22'h10041, d2);
        scr_cs = 1'b0;
        tick();

        // Reset during WAIT_DATA abandons the fetch; late data_rdy is ignored
        obj_cs = 1'b1; obj_addr = 18'h00500;
        exp_q.push_back(22'h00500);
        tick();
        wait_req();
        do_ack(1);
        obj_cs = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        data_rdy = 1'b1; data_read = 16'hdead;
        tick();
        data_rdy = 1'b0;
        tick();
        check("rstmid_req", 32'(sdram_req), 32'd0);
        check("rstmid_state", 32'(fsm_state), 32'd0);
        check("rstmid_data", 32'({obj_data | scr_data | chr_data}), 32'd0);
        obj_cs = 1'b1; scr_cs = 1'b1; chr_cs = 1'b1;
        scr_addr = 17'h00000; chr_addr = 15'h0000; obj_addr = 18'h00000;
        #1;
        check("rstmid_oks", 32'({obj_ok, scr_ok, chr_ok}), 32'd0);
        obj_cs = 1'b0; scr_cs = 1'b0; chr_cs = 1'b0;
        tick();

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/jtdd_rom_arb.md
JTDD_ROM_ARB -- requirements
Module: jtdd_rom_arb

Interface
REQ-001 SHALL have parameter OBJ_AW, default 18, obj requester word-address width.
REQ-002 SHALL have parameter SCR_AW, default 17, scroll requester word-address width.
REQ-003 SHALL have parameter CHR_AW, default 15, char requester word-address width.
REQ-004 SHALL have parameters OBJ_OFFSET, SCR_OFFSET, CHR_OFFSET, defaults 22'h00000, 22'h10000, 22'h30000, SDRAM word base per requester.
REQ-005 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-006 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-007 SHALL have ports obj_cs/scr_cs/chr_cs, input, 1 each, requester wants data at its address.
REQ-008 SHALL have ports obj_addr/scr_addr/chr_addr, input, OBJ_AW/SCR_AW/CHR_AW, requested word address.
REQ-009 SHALL have ports obj_data/scr_data/chr_data, output, 16 each, slot data register.
REQ-010 SHALL have ports obj_ok/scr_ok/chr_ok, output, 1 each, data valid for current address.
REQ-011 SHALL have ports sdram_req output 1, sdram_addr output 22, sdram_ack input 1, data_rdy input 1, data_read input 16.

Function
REQ-012 Each slot SHALL hold valid bit, stored address, 16-bit data.
REQ-013 Slot pending SHALL be cs && (!valid || stored address != current address).
REQ-014 X_ok SHALL be combinational: cs && valid && stored address == current address; changes of X_addr drop X_ok in the same cycle.
REQ-015 FSM states SHALL be IDLE, WAIT_ACK, WAIT_DATA.
REQ-016 IDLE: any slot pending -> latch winner index and address, sdram_addr <= offset + zero-extended address (22-bit, wraps mod 2^22), sdram_req <= 1, go WAIT_ACK; no pending -> stay.
REQ-017 Fixed priority (baseline) SHALL be obj > scr > chr.
REQ-018 WAIT_ACK: sdram_req and sdram_addr held until sdram_ack=1; on ack sdram_req <= 0, go WAIT_DATA.
REQ-019 WAIT_DATA: on data_rdy=1 winner slot data <= data_read, stored address <= latched address, valid <= 1, go IDLE.
REQ-020 Latency: pending in cycle n -> sdram_req high in n+1; data_rdy in cycle m -> X_ok high in m+1 if address unchanged.
REQ-021 Back-to-back: IDLE SHALL spend exactly one cycle before the next sdram_req.
REQ-022 Requester address change or cs drop during fetch: fetch SHALL complete and store latched address; ok stays low on mismatch; re-arbitrated next IDLE.
REQ-023 data_rdy or sdram_ack outside their waiting state SHALL be ignored.
REQ-024 Non-winner slots SHALL keep data/valid unchanged during a fetch.

Reset
REQ-025 On rst: state IDLE, sdram_req 0, sdram_addr 0, all valid 0, all slot data 0, stored addresses 0, RR pointer at obj; all X_ok 0.
REQ-026 rst mid-fetch SHALL abandon the transaction; later data_rdy ignored.

Configuration
REQ-027 Macro JTDD_ARB_RR_EN defined: round-robin; search starts at slot after last winner, order obj->scr->chr->obj.
REQ-028 Macro JTDD_ARB_RR_EN undefined: fixed priority per REQ-017; no pointer logic.

Verification
REQ-029 obj_cs=1 obj_addr=18'h00123, ack after 2 cycles, data_rdy with 16'hBEEF -> sdram_addr=22'h00123, obj_data=16'hBEEF, obj_ok=1 one cycle after data_rdy.
REQ-030 chr_cs=1 chr_addr=15'h0010 -> sdram_addr=22'h30010; then chr_addr=15'h0011 -> chr_ok falls same cycle, new req to 22'h30011.
REQ-031 all three cs rise together, no macro -> order obj, scr, chr; with JTDD_ARB_RR_EN and obj kept re-requesting (address steps) -> obj, scr, chr, obj.
REQ-032 scr_addr changed from 17'h00040 to 17'h00041 in WAIT_DATA -> stored 17'h00040, scr_ok=0, second fetch to 22'h10041.
REQ-033 rst pulsed in WAIT_DATA, then data_rdy=1 -> all ok=0, sdram_req=0, no slot written.
REQ-034 data_rdy pulsed while IDLE, no pending -> no state or slot change.
